// File: rtl/risc16_pkg.sv
// ============================================================================
// Module      : risc16_pkg
// Description : Shared opcodes, instruction field positions and immediate
//               helpers for the RiSC-16 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc16_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam int c_OP_MSB   = 15;
   localparam int c_OP_LSB   = 13;
   localparam int c_RA_MSB   = 12;
   localparam int c_RA_LSB   = 10;
   localparam int c_RB_MSB   = 9;
   localparam int c_RB_LSB   = 7;
   localparam int c_RC_MSB   = 2;
   localparam int c_RC_LSB   = 0;
   localparam int c_SIMM_MSB = 6;
   localparam int c_IMM_MSB  = 9;

   function automatic logic [15:0] sext7(input logic [6:0] i_val);
      return {{9{i_val[6]}}, i_val};
   endfunction

endpackage

`default_nettype wire

// File: rtl/risc16_regfile.sv
// ============================================================================
// Module      : risc16_regfile
// Description : 8x16 register file, two combinational read ports, one
//               synchronous write port, r0 fixed at zero, async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc16_regfile #(
   parameter int p_WORD_LEN = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [2:0]            i_rd_a_addr,
   output logic [p_WORD_LEN-1:0] o_rd_a_data,
   input  logic [2:0]            i_rd_b_addr,
   output logic [p_WORD_LEN-1:0] o_rd_b_data,
   input  logic                  i_wr_en,
   input  logic [2:0]            i_wr_addr,
   input  logic [p_WORD_LEN-1:0] i_wr_data
);

   logic [p_WORD_LEN-1:0] w_regs [8];

   assign w_regs[0] = '0;

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_regs
         logic [p_WORD_LEN-1:0] r_q;
         always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
               r_q <= '0;
            end else if (i_wr_en && (i_wr_addr == 3'(gi))) begin
               r_q <= i_wr_data;
            end
         end
         assign w_regs[gi] = r_q;
      end
   endgenerate

   assign o_rd_a_data = w_regs[i_rd_a_addr];
   assign o_rd_b_data = w_regs[i_rd_b_addr];

endmodule

`default_nettype wire

// File: rtl/risc16_core.sv
// ============================================================================
// Module      : risc16_core
// Description : Single-cycle RiSC-16 core. Optional HALT encoding enabled by
//               defining RISC16_HALT_EN (adds o_halt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc16_core
   import risc16_pkg::*;
#(
   parameter int                  p_WORD_LEN = 16,
   parameter logic [p_WORD_LEN-1:0] p_RESET_PC = 16'h0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [p_WORD_LEN-1:0] i_inst,
   output logic [p_WORD_LEN-1:0] o_pc,
   input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
   output logic [p_WORD_LEN-1:0] o_mem_wr_data,
   output logic [p_WORD_LEN-1:0] o_mem_addr,
   output logic                  o_mem_wr_en
`ifdef RISC16_HALT_EN
   ,
   output logic                  o_halt
`endif
);

   localparam logic [p_WORD_LEN-1:0] c_ONE = {{(p_WORD_LEN-1){1'b0}}, 1'b1};

   logic [p_WORD_LEN-1:0] r_pc;
   logic [2:0]            w_op;
   logic [2:0]            w_ra;
   logic [2:0]            w_rb;
   logic [2:0]            w_rc;
   logic [p_WORD_LEN-1:0] w_simm;
   logic [p_WORD_LEN-1:0] w_lui;
   logic [p_WORD_LEN-1:0] w_pc_inc;
   logic [2:0]            w_rd_a_addr;
   logic [p_WORD_LEN-1:0] w_rd_a_data;
   logic [p_WORD_LEN-1:0] w_rb_data;
   logic [p_WORD_LEN-1:0] w_next_pc;
   logic                  w_rf_wr_en;
   logic [p_WORD_LEN-1:0] w_rf_wr_data;
   logic                  w_stall;

   assign w_op     = i_inst[c_OP_MSB:c_OP_LSB];
   assign w_ra     = i_inst[c_RA_MSB:c_RA_LSB];
   assign w_rb     = i_inst[c_RB_MSB:c_RB_LSB];
   assign w_rc     = i_inst[c_RC_MSB:c_RC_LSB];
   assign w_simm   = sext7(i_inst[c_SIMM_MSB:0]);
   assign w_lui    = {i_inst[c_IMM_MSB:0], 6'b0};
   assign w_pc_inc = r_pc + c_ONE;

   // Port A carries rC for the two register-register ops, rA otherwise.
   assign w_rd_a_addr = ((w_op == OP_ADD) || (w_op == OP_NAND)) ? w_rc : w_ra;

   risc16_regfile #(
      .p_WORD_LEN (p_WORD_LEN)
   ) u_regfile (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rd_a_addr (w_rd_a_addr),
      .o_rd_a_data (w_rd_a_data),
      .i_rd_b_addr (w_rb),
      .o_rd_b_data (w_rb_data),
      .i_wr_en     (w_rf_wr_en),
      .i_wr_addr   (w_ra),
      .i_wr_data   (w_rf_wr_data)
   );

`ifdef RISC16_HALT_EN
   logic r_halt;
   logic w_halt_inst;

   assign w_halt_inst = (w_op == OP_JALR) && (w_ra == 3'd0) && (w_rb == 3'd0) &&
                        (i_inst[c_SIMM_MSB:0] != 7'd0);
   assign w_stall     = r_halt | w_halt_inst;
   assign o_halt      = r_halt;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_halt <= 1'b0;
      end else if (w_halt_inst) begin
         r_halt <= 1'b1;
      end
   end
`else
   assign w_stall = 1'b0;
`endif

   always_comb begin
      w_rf_wr_en   = 1'b0;
      w_rf_wr_data = '0;
      w_next_pc    = w_pc_inc;
      case (w_op)
         OP_ADD:  begin w_rf_wr_en = 1'b1; w_rf_wr_data = w_rb_data + w_rd_a_data; end
         OP_ADDI: begin w_rf_wr_en = 1'b1; w_rf_wr_data = w_rb_data + w_simm; end
         OP_NAND: begin w_rf_wr_en = 1'b1; w_rf_wr_data = ~(w_rb_data & w_rd_a_data); end
         OP_LUI:  begin w_rf_wr_en = 1'b1; w_rf_wr_data = w_lui; end
         OP_LW:   begin w_rf_wr_en = 1'b1; w_rf_wr_data = i_mem_rd_data; end
         OP_BEQ:  begin
            if (w_rd_a_data == w_rb_data) begin
               w_next_pc = w_pc_inc + w_simm;
            end
         end
         OP_JALR: begin
            w_rf_wr_en   = 1'b1;
            w_rf_wr_data = w_pc_inc;
            w_next_pc    = w_rb_data;
         end
         default: ;
      endcase
      if (w_stall) begin
         w_rf_wr_en = 1'b0;
         w_next_pc  = r_pc;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pc <= p_RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   assign o_pc          = r_pc;
   assign o_mem_addr    = w_rb_data + w_simm;
   assign o_mem_wr_data = w_rd_a_data;
   // Gated by reset directly so an in-flight store is dropped the moment reset asserts.
   assign o_mem_wr_en   = (w_op == OP_SW) && i_rst && !w_stall;

endmodule

`default_nettype wire

// File: tb/tb_risc16_core.sv
// ============================================================================
// Module      : tb_risc16_core
// Description : Directed self-checking bench for risc16_core; register
//               contents are observed through SW probes on the store port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc16_core;

   logic        i_clk;
   logic        i_rst;
   logic [15:0] i_inst;
   logic [15:0] o_pc;
   logic [15:0] i_mem_rd_data;
   logic [15:0] o_mem_wr_data;
   logic [15:0] o_mem_addr;
   logic        o_mem_wr_en;
`ifdef RISC16_HALT_EN
   logic        o_halt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   risc16_core #(
      .p_WORD_LEN (16),
      .p_RESET_PC (16'h0000)
   ) u_dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_inst        (i_inst),
      .o_pc          (o_pc),
      .i_mem_rd_data (i_mem_rd_data),
      .o_mem_wr_data (o_mem_wr_data),
      .o_mem_addr    (o_mem_addr),
      .o_mem_wr_en   (o_mem_wr_en)
`ifdef RISC16_HALT_EN
      ,
      .o_halt        (o_halt)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [2:0] c);
      return {op, a, b, 4'b0000, c};
   endfunction

   function automatic logic [15:0] enc_rri(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [6:0] imm);
      return {op, a, b, imm};
   endfunction

   function automatic logic [15:0] enc_lui(input logic [2:0] a, input logic [9:0] imm);
      return {3'b011, a, imm};
   endfunction

   task automatic exec(input logic [15:0] inst);
      i_inst = inst;
      @(posedge i_clk);
      #1;
   endtask

   task automatic show(input logic [15:0] inst);
      i_inst = inst;
      #1;
   endtask

   task automatic do_reset;
      i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      i_inst = enc_rri(3'b100, 3'd1, 3'd0, 7'd0);
      i_mem_rd_data = 16'h0000;
      #2;
      i_rst = 1'b0;
      #1;
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL reset_pc: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
      n_total++;
      if (o_mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected %b", o_mem_wr_en, 1'b0);
      else n_pass++;
`ifdef RISC16_HALT_EN
      n_total++;
      if (o_halt !== 1'b0) $display("FAIL reset_halt: got %b expected %b", o_halt, 1'b0);
      else n_pass++;
`endif
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL release_pc: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
   endtask

   task automatic test_alu;
      exec(enc_rri(3'b001, 3'd1, 3'd0, 7'd5));
      exec(enc_rri(3'b001, 3'd2, 3'd0, 7'h7D));
      exec(enc_rrr(3'b000, 3'd3, 3'd1, 3'd2));
      n_total++;
      if (o_pc !== 16'd3) $display("FAIL alu_pc: got %h expected %h", o_pc, 16'd3);
      else n_pass++;
      show(enc_rri(3'b100, 3'd3, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'd2) $display("FAIL add_r3: got %h expected %h", o_mem_wr_data, 16'd2);
      else n_pass++;
      n_total++;
      if (o_mem_wr_en !== 1'b1) $display("FAIL probe_wr_en: got %b expected %b", o_mem_wr_en, 1'b1);
      else n_pass++;
      show(enc_rri(3'b100, 3'd2, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'hFFFD) $display("FAIL addi_neg_r2: got %h expected %h", o_mem_wr_data, 16'hFFFD);
      else n_pass++;
   endtask

   task automatic test_logic;
      exec(enc_lui(3'd4, 10'h3FF));
      exec(enc_rri(3'b001, 3'd4, 3'd4, 7'h3F));
      exec(enc_rrr(3'b010, 3'd5, 3'd4, 3'd4));
      exec(enc_rri(3'b001, 3'd0, 3'd0, 7'd7));
      n_total++;
      if (o_pc !== 16'd7) $display("FAIL logic_pc: got %h expected %h", o_pc, 16'd7);
      else n_pass++;
      show(enc_rri(3'b100, 3'd4, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'hFFFF) $display("FAIL lui_addi_r4: got %h expected %h", o_mem_wr_data, 16'hFFFF);
      else n_pass++;
      show(enc_rri(3'b100, 3'd5, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'h0000) $display("FAIL nand_r5: got %h expected %h", o_mem_wr_data, 16'h0000);
      else n_pass++;
      show(enc_rri(3'b100, 3'd0, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'h0000) $display("FAIL r0_zero: got %h expected %h", o_mem_wr_data, 16'h0000);
      else n_pass++;
      show(enc_rri(3'b100, 3'd0, 3'd4, 7'd1));
      n_total++;
      if (o_mem_addr !== 16'h0000) $display("FAIL addr_wrap: got %h expected %h", o_mem_addr, 16'h0000);
      else n_pass++;
   endtask

   task automatic test_mem;
      exec(enc_rri(3'b001, 3'd1, 3'd0, 7'd9));
      show(enc_rri(3'b100, 3'd1, 3'd0, 7'd4));
      n_total++;
      if (o_mem_wr_en !== 1'b1) $display("FAIL sw_wr_en: got %b expected %b", o_mem_wr_en, 1'b1);
      else n_pass++;
      n_total++;
      if (o_mem_addr !== 16'd4) $display("FAIL sw_addr: got %h expected %h", o_mem_addr, 16'd4);
      else n_pass++;
      n_total++;
      if (o_mem_wr_data !== 16'd9) $display("FAIL sw_data: got %h expected %h", o_mem_wr_data, 16'd9);
      else n_pass++;
      exec(enc_rri(3'b100, 3'd1, 3'd0, 7'd4));
      i_mem_rd_data = 16'd9;
      show(enc_rri(3'b101, 3'd6, 3'd0, 7'd4));
      n_total++;
      if (o_mem_wr_en !== 1'b0) $display("FAIL lw_wr_en: got %b expected %b", o_mem_wr_en, 1'b0);
      else n_pass++;
      n_total++;
      if (o_mem_addr !== 16'd4) $display("FAIL lw_addr: got %h expected %h", o_mem_addr, 16'd4);
      else n_pass++;
      exec(enc_rri(3'b101, 3'd6, 3'd0, 7'd4));
      i_mem_rd_data = 16'h0000;
      show(enc_rri(3'b100, 3'd6, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'd9) $display("FAIL lw_r6: got %h expected %h", o_mem_wr_data, 16'd9);
      else n_pass++;
      n_total++;
      if (o_pc !== 16'd10) $display("FAIL mem_pc: got %h expected %h", o_pc, 16'd10);
      else n_pass++;
   endtask

   task automatic test_branch;
      exec(enc_rri(3'b110, 3'd1, 3'd1, 7'd2));
      n_total++;
      if (o_pc !== 16'd13) $display("FAIL beq_taken: got %h expected %h", o_pc, 16'd13);
      else n_pass++;
      exec(enc_rri(3'b110, 3'd1, 3'd0, 7'd2));
      n_total++;
      if (o_pc !== 16'd14) $display("FAIL beq_not_taken: got %h expected %h", o_pc, 16'd14);
      else n_pass++;
      exec(enc_rri(3'b110, 3'd0, 3'd0, 7'h7F));
      exec(enc_rri(3'b110, 3'd0, 3'd0, 7'h7F));
      n_total++;
      if (o_pc !== 16'd14) $display("FAIL beq_self_loop: got %h expected %h", o_pc, 16'd14);
      else n_pass++;
   endtask

   task automatic test_jalr;
      exec(enc_rri(3'b001, 3'd2, 3'd0, 7'd20));
      exec(enc_rri(3'b111, 3'd7, 3'd2, 7'd0));
      n_total++;
      if (o_pc !== 16'd20) $display("FAIL jalr_pc: got %h expected %h", o_pc, 16'd20);
      else n_pass++;
      show(enc_rri(3'b100, 3'd7, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'd16) $display("FAIL jalr_link: got %h expected %h", o_mem_wr_data, 16'd16);
      else n_pass++;
      exec(enc_rri(3'b001, 3'd2, 3'd0, 7'd30));
      exec(enc_rri(3'b111, 3'd2, 3'd2, 7'd0));
      n_total++;
      if (o_pc !== 16'd30) $display("FAIL jalr_same_reg_pc: got %h expected %h", o_pc, 16'd30);
      else n_pass++;
      show(enc_rri(3'b100, 3'd2, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'd22) $display("FAIL jalr_same_reg_link: got %h expected %h", o_mem_wr_data, 16'd22);
      else n_pass++;
   endtask

   task automatic test_wrap;
      do_reset();
      exec(enc_rri(3'b110, 3'd0, 3'd0, 7'h7E));
      n_total++;
      if (o_pc !== 16'hFFFF) $display("FAIL beq_wrap_back: got %h expected %h", o_pc, 16'hFFFF);
      else n_pass++;
      exec(enc_rri(3'b001, 3'd0, 3'd0, 7'd0));
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL pc_wrap_fwd: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
   endtask

   task automatic test_async_reset;
      exec(enc_rri(3'b001, 3'd1, 3'd0, 7'd9));
      i_inst = enc_rri(3'b100, 3'd1, 3'd0, 7'd4);
      #2;
      i_rst = 1'b0;
      #1;
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL async_rst_pc: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
      n_total++;
      if (o_mem_wr_en !== 1'b0) $display("FAIL async_rst_wr_en: got %b expected %b", o_mem_wr_en, 1'b0);
      else n_pass++;
      @(posedge i_clk);
      #1;
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL rst_hold_pc: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
      @(negedge i_clk);
      i_rst = 1'b1;
      show(enc_rri(3'b100, 3'd1, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'h0000) $display("FAIL rst_clears_r1: got %h expected %h", o_mem_wr_data, 16'h0000);
      else n_pass++;
   endtask

   task automatic test_halt;
      do_reset();
      exec(enc_rri(3'b001, 3'd1, 3'd0, 7'd3));
      show(16'hE001);
      n_total++;
      if (o_mem_wr_en !== 1'b0) $display("FAIL halt_inst_wr_en: got %b expected %b", o_mem_wr_en, 1'b0);
      else n_pass++;
      exec(16'hE001);
`ifdef RISC16_HALT_EN
      n_total++;
      if (o_halt !== 1'b1) $display("FAIL halt_flag: got %b expected %b", o_halt, 1'b1);
      else n_pass++;
      n_total++;
      if (o_pc !== 16'd1) $display("FAIL halt_pc_frozen: got %h expected %h", o_pc, 16'd1);
      else n_pass++;
      exec(enc_rri(3'b001, 3'd1, 3'd0, 7'd7));
      n_total++;
      if (o_pc !== 16'd1) $display("FAIL halt_pc_held: got %h expected %h", o_pc, 16'd1);
      else n_pass++;
      show(enc_rri(3'b100, 3'd1, 3'd0, 7'd0));
      n_total++;
      if (o_mem_wr_data !== 16'd3) $display("FAIL halt_no_reg_write: got %h expected %h", o_mem_wr_data, 16'd3);
      else n_pass++;
      n_total++;
      if (o_mem_wr_en !== 1'b0) $display("FAIL halt_no_store: got %b expected %b", o_mem_wr_en, 1'b0);
      else n_pass++;
`else
      n_total++;
      if (o_pc !== 16'h0000) $display("FAIL halt_enc_as_jalr: got %h expected %h", o_pc, 16'h0000);
      else n_pass++;
`endif
   endtask

   initial begin
      i_rst         = 1'b1;
      i_inst        = 16'h0000;
      i_mem_rd_data = 16'h0000;
      test_reset();
      test_alu();
      test_logic();
      test_mem();
      test_branch();
      test_jalr();
      test_wrap();
      test_async_reset();
      test_halt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/risc16_core.md
Name: risc16_core

Overview:
- Single-cycle RiSC-16 processor core: 16-bit words, 8 general registers (r0 hard-wired to 0), word-addressed PC.
- Fetches from an external combinational instruction memory indexed by o_pc.
- Accesses an external data memory: combinational read, write on the clock edge.
- Instantiated by the system top level next to instruction ROM and data RAM.

Parameters:
- p_WORD_LEN, 16, datapath/instruction/address width (only 16 supported)
- p_RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_inst  in  16  instruction at address o_pc (combinational)
- o_pc  out  16  current program counter
- i_mem_rd_data  in  16  data-memory read data for o_mem_addr (combinational)
- o_mem_wr_data  out  16  store data
- o_mem_addr  out  16  data-memory address
- o_mem_wr_en  out  1  store strobe; memory writes at the next rising edge

Behaviour:
- Reset (i_rst=0, asynchronous): PC=p_RESET_PC, r1..r7=0, o_mem_wr_en forced 0. Other outputs are combinational from state and i_inst.
- Decode fields:
  - op=inst[15:13], rA=[12:10], rB=[9:7], rC=[2:0]
  - simm7=[6:0], sign-extended to 16 bits
  - imm10=[9:0]
- One instruction retires per rising edge; all arithmetic is modulo 2^16.
- Default next PC = PC+1.
- Instructions:
  - 000 ADD: rA=rB+rC
  - 001 ADDI: rA=rB+simm7
  - 010 NAND: rA=~(rB&rC)
  - 011 LUI: rA={imm10,6'b0}
  - 100 SW: o_mem_addr=rB+simm7, o_mem_wr_data=rA, o_mem_wr_en=1
  - 101 LW: o_mem_addr=rB+simm7; rA=i_mem_rd_data (same cycle)
  - 110 BEQ: if rA==rB then PC=PC+1+simm7, else PC+1
  - 111 JALR: rA=PC+1 (old PC), PC=rB (value read before the write)
- Writes to r0 are discarded; reads of r0 return 0.
- o_mem_addr always equals rB+simm7; o_mem_wr_data always equals rA. This is harmless when o_mem_wr_en=0.
- o_mem_wr_en=1 only for SW with reset deasserted.
- Register reads are combinational; the write-back occurs at the edge. An instruction never sees its own result.
- PC wraps 16'hFFFF -> 0. A backward BEQ below 0 wraps modulo 2^16.
- If reset is asserted mid-cycle, the in-flight instruction is discarded and no write reaches registers or memory.

Optional Feature:
- Macro RISC16_HALT_EN.
- With the macro: extra output o_halt (1 bit).
  - JALR with rA=0, rB=0 and simm7!=0 is HALT.
  - The PC freezes and no register or memory writes occur.
  - o_halt goes to 1 from the next edge and stays set until reset.
- Without the macro: no o_halt port; that encoding behaves as an ordinary JALR (PC=0).

Decomposition:
- Package risc16_pkg holds:
  - opcode localparams OP_ADD..OP_JALR
  - field bit positions
  - a sign-extend function
- One sub-module is natural: risc16_regfile (8x16, two async read ports, one sync write port, r0 fixed to 0, async active-low clear).
- ALU and next-PC logic stay inline.

Test Plan:
- Reset then release -> o_pc=0. Run ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2, o_pc=3.
- LUI r4,0x3FF; ADDI r4,r4,0x3F -> r4=16'hFFFF; NAND r5,r4,r4 -> r5=0. ADDI r0,r0,7 -> r0 still 0.
- ADDI r1,r0,9; SW r1,r0,4 -> o_mem_wr_en=1, addr=4, data=9 in that cycle. LW r6,r0,4 with memory returning 9 -> r6=9.
- BEQ r1,r1,2 at PC=5 -> PC=8. BEQ r1,r0,2 with r1!=0 -> PC=6. BEQ r0,r0,-1 at PC=10 -> PC=10 (self-loop).
- ADDI r2,r0,20; JALR r7,r2 at PC=12 -> r7=13, PC=20.
- Assert reset asynchronously mid-program with an SW on i_inst -> PC=0 immediately, o_mem_wr_en=0, registers cleared. With RISC16_HALT_EN, instruction 16'hE001 -> o_halt=1 and PC frozen.
